wf_neopixel_chain_if: RTL and testbench

- Parametrised serial driver for WS2812B/SK6805-class addressable LED chains.
- Generalises the fixed single-timing driver:
  - per-bit hi/lo times set in clocks, so the block works at any clk frequency;
  - 24-bit RGB or 32-bit RGBW pixels;
  - runtime frame length;
  - explicit start/busy/done handshake;
  - optional auto-refresh.
- Reads pixel words from a synchronous pixel RAM (1-cycle read latency) and prefetches so pixel boundaries have no gaps.
- Sits between the pixel frame buffer and the WF_NEO pin.

---
 rtl/wf_neopixel_chain_if.sv | 205 ++++++++++++++++++++
 tb/tb_wf_neopixel_chain_if.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wf_neopixel_chain_if.sv
// Purpose: serial driver for WS2812B/SK6805 LED chains, pixels streamed from a synchronous pixel RAM.
// Latency: start sampled at edge N -> dout rises at edge N+2; bits and pixels stream back to back.
// Backpressure: none; start is honoured only in IDLE and ignored (not queued) while busy.
module wf_neopixel_chain_if #(
    parameter int NUM_PIXELS   = 8,
    parameter int ADDR_W       = 8,
    parameter int PIXEL_W      = 24,
    parameter int T1H          = 10,
    parameter int T1L          = 5,
    parameter int T0H          = 5,
    parameter int T0L          = 10,
    parameter int T_RESET      = 600,
    parameter int CNT_W        = 10,
    parameter int AUTO_REFRESH = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W:0]    frame_len,
    output logic [ADDR_W-1:0]  ram_rd_addr,
    input  logic [PIXEL_W-1:0] ram_rd_data,
    output logic               busy,
    output logic               frame_done,
    output logic               dout
);
    localparam int BIT_W = $clog2(PIXEL_W);
    localparam logic [ADDR_W:0]  MAX_LEN  = (ADDR_W+1)'(NUM_PIXELS);
    localparam logic [ADDR_W:0]  ONE      = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]  TWO      = (ADDR_W+1)'(2);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PIXEL_W - 1);
    localparam logic [CNT_W-1:0] T1H_END  = CNT_W'(T1H - 1);
    localparam logic [CNT_W-1:0] T1L_END  = CNT_W'(T1L - 1);
    localparam logic [CNT_W-1:0] T0H_END  = CNT_W'(T0H - 1);
    localparam logic [CNT_W-1:0] T0L_END  = CNT_W'(T0L - 1);
    localparam logic [CNT_W-1:0] TRS_END  = CNT_W'(T_RESET - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HIGH, S_LOW, S_LATCH} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [ADDR_W:0]    pix_q, pix_d;
    logic [ADDR_W:0]    len_q, len_d;
    logic [PIXEL_W-1:0] shift_q, shift_d;
    logic [PIXEL_W-1:0] pref_q, pref_d;
    logic [1:0]         pf_cnt_q, pf_cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dout_q, dout_d;

    logic [ADDR_W:0]    len_clamp;
    logic [CNT_W-1:0]   hi_end, lo_end;

    assign len_clamp   = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;
    assign ram_rd_addr = addr_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign dout        = dout_q;

    // Phase lengths for the bit currently at the top of the shift register.
    always_comb begin
        hi_end = shift_q[PIXEL_W-1] ? T1H_END : T0H_END;
        lo_end = shift_q[PIXEL_W-1] ? T1L_END : T0L_END;
    end

    // Next-state logic for the frame sequencer, bit timer and pixel prefetch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        pix_d    = pix_q;
        len_d    = len_q;
        shift_d  = shift_q;
        pref_d   = pref_q;
        pf_cnt_d = pf_cnt_q;
        addr_d   = addr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dout_d   = dout_q;

        // A new address reaches ram_rd_data two edges after it is issued.
        if (pf_cnt_q != 2'd0) begin
            pf_cnt_d = pf_cnt_q - 2'd1;
        end
        if (pf_cnt_q == 2'd1) begin
            pref_d = ram_rd_data;
        end

        case (state_q)
            S_IDLE: begin
                addr_d = '0;
                dout_d = 1'b0;
                cnt_d  = '0;
                if (start) begin
                    len_d   = len_clamp;
                    busy_d  = 1'b1;
                    state_d = (len_clamp == '0) ? S_LATCH : S_LOAD;
                end
            end
            S_LOAD: begin
                // First cycle lets the read of address 0 settle (it may have just been issued).
                if (cnt_q == '0) begin
                    cnt_d = CNT_W'(1);
                end else begin
                    cnt_d    = '0;
                    shift_d  = ram_rd_data;
                    bit_d    = '0;
                    pix_d    = '0;
                    pf_cnt_d = 2'd2;
                    if (len_q > ONE) begin
                        addr_d = ADDR_W'(1);
                    end
                    dout_d  = 1'b1;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (cnt_q == hi_end) begin
                    cnt_d   = '0;
                    dout_d  = 1'b0;
                    state_d = S_LOW;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LOW: begin
                if (cnt_q == lo_end) begin
                    cnt_d = '0;
                    if (bit_q != LAST_BIT) begin
                        shift_d = {shift_q[PIXEL_W-2:0], 1'b0};
                        bit_d   = bit_q + BIT_W'(1);
                        dout_d  = 1'b1;
                        state_d = S_HIGH;
                    end else if ((pix_q + ONE) < len_q) begin
                        shift_d  = pref_q;
                        bit_d    = '0;
                        pix_d    = pix_q + ONE;
                        pf_cnt_d = 2'd2;
                        if ((pix_q + TWO) < len_q) begin
                            addr_d = addr_q + ADDR_W'(1);
                        end
                        dout_d  = 1'b1;
                        state_d = S_HIGH;
                    end else begin
                        state_d = S_LATCH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LATCH: begin
                dout_d = 1'b0;
                if (cnt_q == TRS_END) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                    addr_d = '0;
                    if (AUTO_REFRESH != 0) begin
                        len_d   = len_clamp;
                        state_d = (len_clamp == '0) ? S_LATCH : S_LOAD;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset forces the line low immediately, even mid-bit or mid-latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            pix_q    <= '0;
            len_q    <= '0;
            shift_q  <= '0;
            pref_q   <= '0;
            pf_cnt_q <= '0;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            pix_q    <= pix_d;
            len_q    <= len_d;
            shift_q  <= shift_d;
            pref_q   <= pref_d;
            pf_cnt_q <= pf_cnt_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dout_q   <= dout_d;
        end
    end
endmodule

// File: tb/tb_wf_neopixel_chain_if.sv
// Bench for wf_neopixel_chain_if: an RGB instance and an RGBW auto-refresh instance,
// each with a registered pixel RAM model; dout is decoded back into bits and scored.
module tb_wf_neopixel_chain_if;
    localparam int T1H = 3, T1L = 2, T0H = 2, T0L = 3, T_RESET = 20, NP = 4, AW = 8;
    localparam int BITP = T1H + T1L;

    typedef struct {
        int                len_in;
        logic [0:3][23:0]  px;
        int                exp_len;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0, start = 1'b0;
    logic [AW:0]   frame_len = '0;
    logic [AW-1:0] ram_rd_addr;
    logic [23:0]   ram_rd_data = '0;
    logic          busy, frame_done, dout;
    logic [23:0]   mem [NP];

    logic          rst_w = 1'b0, start_w = 1'b0;
    logic [AW:0]   frame_len_w = '0;
    logic [AW-1:0] addr_w;
    logic [31:0]   data_w = '0;
    logic          busy_w, done_w, dout_w;
    logic [31:0]   memw [NP];

    int checks = 0, errors = 0, cyc = 0;
    vec_t vec [5];

    wf_neopixel_chain_if #(
        .NUM_PIXELS(NP), .ADDR_W(AW), .PIXEL_W(24), .T1H(T1H), .T1L(T1L), .T0H(T0H), .T0L(T0L),
        .T_RESET(T_RESET), .CNT_W(10), .AUTO_REFRESH(0)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .busy(busy), .frame_done(frame_done), .dout(dout)
    );

    wf_neopixel_chain_if #(
        .NUM_PIXELS(NP), .ADDR_W(AW), .PIXEL_W(32), .T1H(T1H), .T1L(T1L), .T0H(T0H), .T0L(T0L),
        .T_RESET(T_RESET), .CNT_W(10), .AUTO_REFRESH(1)
    ) dut_w (
        .clk(clk), .reset(rst_w), .start(start_w), .frame_len(frame_len_w),
        .ram_rd_addr(addr_w), .ram_rd_data(data_w),
        .busy(busy_w), .frame_done(done_w), .dout(dout_w)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) ram_rd_data <= (ram_rd_addr < AW'(NP)) ? mem[ram_rd_addr[1:0]] : '0;
    always @(posedge clk) data_w <= (addr_w < AW'(NP)) ? memw[addr_w[1:0]] : '0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- RGB instance monitor / scoreboard ----------------
    bit   mon_en = 1'b0, prev_d = 1'b0, have_prev = 1'b0, prev_bit = 1'b0;
    int   rise_c = 0, fall_c = 0, first_rise = -1, done_cnt = 0, done_cyc = -1, bits_seen = 0;
    logic [AW-1:0] prev_addr = '0;
    int   addr_log[$];
    bit   exp_q[$];

    always @(negedge clk) begin : mon24
        int h;
        bit eb;
        if (mon_en) begin
            if (dout && !prev_d) begin
                if (have_prev && (cyc - fall_c) < T_RESET)
                    check("low_time", cyc - fall_c, prev_bit ? T1L : T0L);
                if (first_rise < 0) first_rise = cyc;
                rise_c = cyc;
            end
            if (!dout && prev_d) begin
                h = cyc - rise_c;
                fall_c = cyc;
                have_prev = 1'b1;
                bits_seen++;
                if (exp_q.size() == 0) begin
                    check("extra_bit", 1, 0);
                end else begin
                    eb = exp_q.pop_front();
                    prev_bit = eb;
                    check("bit_high_time", h, eb ? T1H : T0H);
                end
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_low_at_done", int'(busy), 0);
            end
            if (ram_rd_addr != prev_addr) addr_log.push_back(int'(ram_rd_addr));
        end
        prev_d = dout;
        prev_addr = ram_rd_addr;
    end

    // ---------------- RGBW instance monitor / scoreboard ----------------
    bit wprev = 1'b0, wmon = 1'b0, wbusy_drop = 1'b0;
    int wrise = 0, wbits = 0, wdone_n = 0;
    bit wexp[$];
    int wdone_cyc[$], wbits_at_done[$];

    always @(negedge clk) begin : monw
        int h;
        bit eb;
        if (wmon && wdone_n < 2) begin
            if (!busy_w) wbusy_drop = 1'b1;
            if (dout_w && !wprev) wrise = cyc;
            if (!dout_w && wprev) begin
                h = cyc - wrise;
                wbits++;
                if (wexp.size() == 0) begin
                    check("w_extra_bit", 1, 0);
                end else begin
                    eb = wexp.pop_front();
                    check("w_bit_high_time", h, eb ? T1H : T0H);
                end
            end
            if (done_w) begin
                wdone_n++;
                wdone_cyc.push_back(cyc);
                wbits_at_done.push_back(wbits);
            end
        end
        wprev = dout_w;
    end

    task automatic push_frame(input int l);
        logic [23:0] w;
        for (int p = 0; p < l; p++) begin
            w = mem[p];
            for (int b = 23; b >= 0; b--) exp_q.push_back(w[b]);
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (done_cnt < target) check("done_timeout", done_cnt, target);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int n, l, exp_done;
        int exp_addr[$];
        for (int i = 0; i < NP; i++) mem[i] = v.px[i];
        l = v.exp_len;
        addr_log.delete();
        first_rise = -1;
        done_cnt = 0;
        bits_seen = 0;
        frame_len = 9'(v.len_in);
        @(negedge clk);
        n = cyc + 1;
        push_frame(l);
        pulse_start();
        frame_len = 9'd3;
        wait_done(1, 1000);
        exp_done = (l == 0) ? n + T_RESET : n + 2 + l * 24 * BITP + T_RESET;
        check("done_edge", done_cyc, exp_done);
        check("first_rise", first_rise, (l == 0) ? -1 : n + 2);
        check("bit_count", bits_seen, l * 24);
        check("bits_left", exp_q.size(), 0);
        for (int k = 1; k < l; k++) exp_addr.push_back(k);
        if (l > 1) exp_addr.push_back(0);
        check("addr_log_len", addr_log.size(), exp_addr.size());
        for (int i = 0; i < addr_log.size() && i < exp_addr.size(); i++)
            check("addr_seq", addr_log[i], exp_addr[i]);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n, k;
        logic [31:0] w;
        vec[0] = '{len_in: 1, px: {24'hA50000, 24'h000000, 24'h000000, 24'h000000}, exp_len: 1};
        vec[1] = '{len_in: 4, px: {24'hFFFFFF, 24'h000000, 24'h800001, 24'h7FFFFE}, exp_len: 4};
        vec[2] = '{len_in: 0, px: {24'h123456, 24'h000000, 24'h000000, 24'h000000}, exp_len: 0};
        vec[3] = '{len_in: 7, px: {24'h123456, 24'hABCDEF, 24'h0F0F0F, 24'hF0F0F0}, exp_len: 4};
        vec[4] = '{len_in: 2, px: {24'h5A5A5A, 24'hC3C3C3, 24'h000000, 24'h000000}, exp_len: 2};
        for (int i = 0; i < NP; i++) mem[i] = '0;
        memw[0] = 32'hA1B2C3D4;
        memw[1] = 32'h11223344;
        memw[2] = 32'h0;
        memw[3] = 32'h0;

        // reset values
        #1;
        reset = 1'b1;
        rst_w = 1'b1;
        #2;
        check("rst_dout", int'(dout), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(frame_done), 0);
        check("rst_addr", int'(ram_rd_addr), 0);
        check("rst_w_dout", int'(dout_w), 0);
        check("rst_w_busy", int'(busy_w), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rst_w = 1'b0;
        mon_en = 1'b1;

        // table-driven frames
        for (int i = 0; i < 5; i++) run_vec(vec[i]);

        // start pulsed while busy is ignored
        done_cnt = 0;
        bits_seen = 0;
        frame_len = 9'd2;
        @(negedge clk);
        n = cyc + 1;
        push_frame(2);
        pulse_start();
        repeat (40) @(negedge clk);
        pulse_start();
        wait_done(1, 1000);
        repeat (300) @(negedge clk);
        check("busy_start_done_count", done_cnt, 1);
        check("busy_start_bits", bits_seen, 48);
        check("busy_start_done_edge", done_cyc, n + 2 + 2 * 24 * BITP + T_RESET);

        // start during the frame_done cycle is accepted
        done_cnt = 0;
        bits_seen = 0;
        frame_len = 9'd1;
        @(negedge clk);
        push_frame(1);
        pulse_start();
        k = 0;
        while (!frame_done && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", int'(frame_done), 1);
        first_rise = -1;
        n = cyc + 1;
        push_frame(1);
        pulse_start();
        wait_done(2, 400);
        check("restart_rise", first_rise, n + 2);
        check("restart_done", done_cyc, n + 2 + 24 * BITP + T_RESET);
        check("restart_bits", bits_seen, 48);
        repeat (3) @(negedge clk);

        // reset inside a HIGH phase
        frame_len = 9'd4;
        @(negedge clk);
        push_frame(4);
        pulse_start();
        k = 0;
        while (!dout && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("reset_pre_dout", int'(dout), 1);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_dout", int'(dout), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_addr", int'(ram_rd_addr), 0);
        mon_en = 1'b0;
        exp_q.delete();
        repeat (5) @(negedge clk);
        reset = 1'b0;
        have_prev = 1'b0;
        mon_en = 1'b1;
        run_vec(vec[1]);

        // RGBW with auto-refresh and a frame_len change for the next frame
        frame_len_w = 9'd2;
        @(negedge clk);
        n = cyc + 1;
        for (int p = 0; p < 2; p++) begin
            w = memw[p];
            for (int b = 31; b >= 0; b--) wexp.push_back(w[b]);
        end
        w = memw[0];
        for (int b = 31; b >= 0; b--) wexp.push_back(w[b]);
        start_w = 1'b1;
        @(negedge clk);
        start_w = 1'b0;
        wmon = 1'b1;
        frame_len_w = 9'd1;
        k = 0;
        while (wdone_n < 2 && k < 1200) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("w_done_count", wdone_n, 2);
        if (wdone_cyc.size() >= 2) begin
            check("w_done0_edge", wdone_cyc[0], n + 2 + 2 * 32 * BITP + T_RESET);
            check("w_done1_edge", wdone_cyc[1], wdone_cyc[0] + 2 + 32 * BITP + T_RESET);
            check("w_bits_frame0", wbits_at_done[0], 64);
            check("w_bits_frame1", wbits_at_done[1], 96);
        end
        check("w_bits_left", wexp.size(), 0);
        check("w_busy_drop", int'(wbusy_drop), 0);
        rst_w = 1'b1;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
